// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, the buffered writeback entry and the starvation FSM states.
package wb_port_arbiter_pkg;

   localparam int ADDR_WIDTH = 5;
   localparam int DATA_WIDTH = 32;
   localparam int REG_COUNT  = 32;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] data;
   } wb_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous buffer of long-latency writeback entries; reset flushes all entries.
module wb_fifo
   import wb_port_arbiter_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  wb_entry_t                    entry,
   input  logic                         pop,
   output logic                         full,
   output logic                         empty,
   output wb_entry_t                    head,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   wb_entry_t       mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= entry;
   end

   // DEPTH is a power of two, so the pointers wrap by overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline priority, buffered long-latency results,
// pending scoreboard and starvation bubble.
//   state | meaning
//   RUN   | pipeline wins the port; lost cycles counted while results wait
//   STALL | one-cycle bubble, buffered head owns the port
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pipe_we_i,
   input  logic [ADDR_WIDTH-1:0] pipe_addr_i,
   input  logic [DATA_WIDTH-1:0] pipe_data_i,
   input  logic                  lu_valid_i,
   output logic                  lu_ready_o,
   input  logic [ADDR_WIDTH-1:0] lu_addr_i,
   input  logic [DATA_WIDTH-1:0] lu_data_i,
   input  logic                  issue_i,
   input  logic [ADDR_WIDTH-1:0] issue_addr_i,
   input  logic [ADDR_WIDTH-1:0] chk_addr1_i,
   input  logic [ADDR_WIDTH-1:0] chk_addr2_i,
   output logic                  busy1_o,
   output logic                  busy2_o,
   output logic                  stall_o,
   output logic                  we_o,
   output logic [ADDR_WIDTH-1:0] wr_addr_o,
   output logic [DATA_WIDTH-1:0] wr_data_o
);

   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int LW = $clog2(STARVE_LIMIT+1);

   wb_state_e            state;
   logic [LW-1:0]        starve_cnt;
   logic [REG_COUNT-1:0] pending;
   logic [REG_COUNT-1:0] pending_set;
   logic [REG_COUNT-1:0] pending_clr;

   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CW-1:0]        fifo_count;
   wb_entry_t            head;
   wb_entry_t            lu_entry;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 pipe_win;

   assign lu_ready_o = (fifo_count < CW'(FIFO_DEPTH));
   // x0 results complete the handshake but are never buffered.
   assign fifo_push  = lu_valid_i && !fifo_full && (lu_addr_i != '0);
   assign lu_entry   = '{addr: lu_addr_i, data: lu_data_i};

   assign stall_o    = (state == STALL);
   assign pipe_win   = pipe_we_i && !stall_o;
   assign fifo_pop   = !pipe_win && !fifo_empty;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .entry (lu_entry),
      .pop   (fifo_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head),
      .count (fifo_count)
   );

   always_comb begin
      wr_addr_o = head.addr;
      wr_data_o = head.data;
      we_o      = 1'b0;
      if (pipe_win) begin
         wr_addr_o = pipe_addr_i;
         wr_data_o = pipe_data_i;
         we_o      = (pipe_addr_i != '0);
      end else if (!fifo_empty) begin
         we_o      = 1'b1;
      end
      if (!rst_n) we_o = 1'b0;
   end

   always_comb begin
      pending_set = '0;
      pending_clr = '0;
      if (issue_i && (issue_addr_i != '0)) pending_set[issue_addr_i] = 1'b1;
      if (fifo_pop) pending_clr[head.addr] = 1'b1;
   end

   // Set is applied after clear so a same-cycle re-issue keeps the bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= (pending & ~pending_clr) | pending_set;
   end

   assign busy1_o = pending[chk_addr1_i];
   assign busy2_o = pending[chk_addr2_i];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         starve_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (pipe_win && !fifo_empty) begin
                  if (starve_cnt == LW'(STARVE_LIMIT-1)) begin
                     state      <= STALL;
                     starve_cnt <= '0;
                  end else begin
                     starve_cnt <= starve_cnt + LW'(1);
                  end
               end else begin
                  starve_cnt <= '0;
               end
            end
            STALL: begin
               state      <= RUN;
               starve_cnt <= '0;
            end
         endcase
      end
   end

   a_issue_free: assert property (@(posedge clk) disable iff (!rst_n)
      issue_i |-> !pending[issue_addr_i]);
   a_pipe_free: assert property (@(posedge clk) disable iff (!rst_n)
      pipe_we_i |-> !pending[pipe_addr_i]);
   a_no_write_in_stall: assert property (@(posedge clk) disable iff (!rst_n)
      pipe_we_i |-> !stall_o);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios followed by random traffic, checked every cycle against a
// queue-based reference of the write port, buffer, pending set and starvation rule.
module tb_wb_port_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 4;

   logic        clk;
   logic        rst_n;
   logic        pipe_we;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        issue;
   logic [4:0]  issue_addr;
   logic [4:0]  chk1;
   logic [4:0]  chk2;
   logic        busy1;
   logic        busy2;
   logic        stall;
   logic        we;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   wb_port_arbiter #(
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pipe_we_i    (pipe_we),
      .pipe_addr_i  (pipe_addr),
      .pipe_data_i  (pipe_data),
      .lu_valid_i   (lu_valid),
      .lu_ready_o   (lu_ready),
      .lu_addr_i    (lu_addr),
      .lu_data_i    (lu_data),
      .issue_i      (issue),
      .issue_addr_i (issue_addr),
      .chk_addr1_i  (chk1),
      .chk_addr2_i  (chk2),
      .busy1_o      (busy1),
      .busy2_o      (busy2),
      .stall_o      (stall),
      .we_o         (we),
      .wr_addr_o    (wr_addr),
      .wr_data_o    (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   ent_t m_q[$];
   bit   m_pend [32];
   int   m_lost;
   bit   m_stall;
   bit   m_rst;
   bit   m_accepted;
   int   outstanding[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   obs_stall = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_lost  = 0;
      m_stall = 1'b0;
      outstanding.delete();
   endtask

   task automatic check_outputs();
      bit   pwin;
      bit   pop;
      bit   exp_we;
      ent_t h;
      pwin   = pipe_we && !m_stall;
      pop    = !pwin && (m_q.size() > 0);
      exp_we = m_rst ? 1'b0 : (pwin ? (pipe_addr != 5'd0) : pop);
      if (stall === 1'b1) obs_stall++;
      chk("lu_ready", lu_ready, (m_q.size() < DEPTH) ? 1 : 0);
      chk("stall", stall, m_stall);
      chk("busy1", busy1, m_pend[chk1]);
      chk("busy2", busy2, m_pend[chk2]);
      chk("we", we, exp_we);
      if (exp_we) begin
         if (pwin) begin
            chk("wr_addr_pipe", wr_addr, pipe_addr);
            chk("wr_data_pipe", wr_data, pipe_data);
         end else begin
            h = m_q[0];
            chk("wr_addr_fifo", wr_addr, h.addr);
            chk("wr_data_fifo", wr_data, h.data);
         end
      end
   endtask

   task automatic update_model();
      bit   pwin;
      bit   pop;
      bit   nonempty;
      ent_t h;
      m_accepted = 1'b0;
      if (m_rst) return;
      nonempty   = (m_q.size() > 0);
      pwin       = pipe_we && !m_stall;
      pop        = !pwin && nonempty;
      m_accepted = lu_valid && (m_q.size() < DEPTH);
      if (pop) begin
         h = m_q.pop_front();
         m_pend[h.addr] = 1'b0;
      end
      if (issue && issue_addr != 5'd0) m_pend[issue_addr] = 1'b1;
      if (m_accepted && lu_addr != 5'd0) m_q.push_back('{addr: lu_addr, data: lu_data});
      if (m_stall) begin
         m_stall = 1'b0;
         m_lost  = 0;
      end else if (nonempty && pwin) begin
         m_lost++;
         if (m_lost == LIMIT) begin
            m_stall = 1'b1;
            m_lost  = 0;
         end
      end else begin
         m_lost = 0;
      end
   endtask

   task automatic cycle();
      if (m_stall) pipe_we = 1'b0;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      update_model();
      #1;
   endtask

   task automatic quiet();
      pipe_we  = 1'b0;
      lu_valid = 1'b0;
      issue    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int a;
      // reset entry state, with a pipeline request present to exercise the we gate
      rst_n = 1'b0; m_rst = 1'b1; model_reset();
      pipe_we = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h1;
      lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
      issue = 1'b0; issue_addr = '0; chk1 = 5'd5; chk2 = 5'd7;
      #1;
      check_outputs();
      cycle(); cycle();
      rst_n = 1'b1; m_rst = 1'b0;
      quiet();
      cycle();

      // idle drain of x5
      issue = 1'b1; issue_addr = 5'd5; chk1 = 5'd5;
      cycle();
      issue = 1'b0;
      lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'hDEADBEEF;
      #1 chk("drain_busy_after_issue", busy1, 1);
      cycle();
      lu_valid = 1'b0;
      #1;
      chk("drain_we", we, 1);
      chk("drain_addr", wr_addr, 5);
      chk("drain_data", wr_data, 32'hDEADBEEF);
      cycle();
      #1 chk("drain_busy_cleared", busy1, 0);

      // pipeline priority over a buffered x7
      issue = 1'b1; issue_addr = 5'd7; chk2 = 5'd7;
      cycle();
      issue = 1'b0;
      lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h22;
      pipe_we = 1'b1; pipe_addr = 5'd4; pipe_data = 32'h44;
      cycle();
      lu_valid = 1'b0;
      pipe_addr = 5'd3; pipe_data = 32'h11;
      #1;
      chk("prio_pipe_addr", wr_addr, 3);
      chk("prio_pipe_data", wr_data, 32'h11);
      cycle();
      pipe_we = 1'b0;
      #1;
      chk("prio_fifo_addr", wr_addr, 7);
      chk("prio_fifo_data", wr_data, 32'h22);
      cycle();

      // fill the buffer while the pipeline writes every cycle
      for (int r = 10; r < 15; r++) begin
         issue = 1'b1; issue_addr = 5'(r);
         cycle();
      end
      issue = 1'b0;
      idx = 0;
      for (int c = 0; c < 30; c++) begin
         pipe_we = 1'b1; pipe_addr = 5'd20; pipe_data = $urandom;
         if (idx < 5) begin
            lu_valid = 1'b1; lu_addr = 5'(10 + idx); lu_data = 32'hA000 + 32'(idx);
         end else begin
            lu_valid = 1'b0;
         end
         cycle();
         if (lu_valid && m_accepted) idx++;
      end
      quiet();
      for (int c = 0; c < 8; c++) cycle();

      // starvation with a single buffered entry
      issue = 1'b1; issue_addr = 5'd9;
      cycle();
      issue = 1'b0;
      lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h9999;
      pipe_we = 1'b1; pipe_addr = 5'd21; pipe_data = 32'h2121;
      cycle();
      lu_valid = 1'b0;
      obs_stall = 0;
      for (int c = 0; c < 8; c++) begin
         pipe_we = 1'b1;
         cycle();
      end
      chk("starve_stall_cycles", obs_stall, 1);
      quiet();
      cycle();

      // x0 results and x0 pipeline writes
      lu_valid = 1'b1; lu_addr = 5'd0; lu_data = 32'h5A5A;
      cycle();
      lu_valid = 1'b0;
      pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h77;
      cycle();
      quiet();
      cycle();

      // reset mid-burst with three results queued
      for (int r = 15; r < 18; r++) begin
         issue = 1'b1; issue_addr = 5'(r);
         cycle();
      end
      issue = 1'b0; chk1 = 5'd15; chk2 = 5'd17;
      for (int r = 15; r < 18; r++) begin
         pipe_we = 1'b1; pipe_addr = 5'd22; pipe_data = $urandom;
         lu_valid = 1'b1; lu_addr = 5'(r); lu_data = $urandom;
         cycle();
      end
      lu_valid = 1'b0;
      rst_n = 1'b0; m_rst = 1'b1; model_reset();
      #1;
      chk("rst_ready", lu_ready, 1);
      chk("rst_busy1", busy1, 0);
      chk("rst_we", we, 0);
      cycle(); cycle();
      rst_n = 1'b1; m_rst = 1'b0;
      quiet();
      for (int c = 0; c < 4; c++) cycle();

      // random traffic
      for (int c = 0; c < 1500; c++) begin
         chk1 = 5'($urandom_range(0, 31));
         chk2 = 5'($urandom_range(0, 31));
         if (!lu_valid) begin
            if ($urandom_range(0, 15) == 0) begin
               lu_valid = 1'b1; lu_addr = 5'd0; lu_data = $urandom;
            end else if (outstanding.size() > 0 && $urandom_range(0, 2) == 0) begin
               lu_valid = 1'b1; lu_addr = 5'(outstanding[0]); lu_data = $urandom;
            end
         end
         issue = 1'b0;
         if ($urandom_range(0, 3) == 0) begin
            a = $urandom_range(1, 31);
            if (!m_pend[a] && !(a inside {outstanding})) begin
               issue = 1'b1; issue_addr = 5'(a);
               outstanding.push_back(a);
            end
         end
         pipe_we = 1'b0;
         if ($urandom_range(0, 9) < 7) begin
            a = $urandom_range(0, 31);
            if (!m_pend[a]) begin
               pipe_we = 1'b1; pipe_addr = 5'(a); pipe_data = $urandom;
            end
         end
         cycle();
         if (lu_valid && m_accepted) begin
            if (lu_addr != 5'd0) void'(outstanding.pop_front());
            lu_valid = 1'b0;
         end
      end
      quiet();
      for (int c = 0; c < 10; c++) cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Writeback port arbiter and pending-register scoreboard in front of the single register-file write port. Two producers share the port:
- The in-order pipeline writeback has priority.
- A long-latency unit (multiplier/divider/load) delivers results through a valid/ready handshake into a small FIFO.

The block tracks which registers await a long-latency result so decode can stall on them. It also forces a one-cycle pipeline bubble when the FIFO starves.

## Interface
Parameters:
- ADDR_WIDTH, from `defines`: register address width (5).
- DATA_WIDTH, from `defines`: register data width (32).
- REG_COUNT, from `defines`: number of registers (32).
- FIFO_DEPTH, 4: long-latency result buffer entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive lost arbitration cycles before a stall is forced; ≥1.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pipe_we_i  in  1  pipeline writeback request
- pipe_addr_i  in  ADDR_WIDTH  pipeline destination register
- pipe_data_i  in  DATA_WIDTH  pipeline result
- lu_valid_i  in  1  long-latency result valid
- lu_ready_o  out  1  FIFO can accept (= not full)
- lu_addr_i  in  ADDR_WIDTH  long-latency destination
- lu_data_i  in  DATA_WIDTH  long-latency result
- issue_i  in  1  long-latency op issued this cycle
- issue_addr_i  in  ADDR_WIDTH  its destination register
- chk_addr1_i, chk_addr2_i  in  ADDR_WIDTH  decode source registers
- busy1_o, busy2_o  out  1  source register pending
- stall_o  out  1  pipeline must not write back this cycle
- we_o  out  1  register-file write enable
- wr_addr_o  out  ADDR_WIDTH  register-file write address
- wr_data_o  out  DATA_WIDTH  register-file write data

## Operation
Arbitration (combinational, per cycle):
- pipe_we_i=1 and stall_o=0: the port carries the pipeline write. The FIFO holds.
- Otherwise, if the FIFO is non-empty: the port carries the FIFO head, and the head pops at the clock edge.
- Otherwise: we_o=0.
- Writes with address 0 drive we_o=0. A FIFO entry with address 0 never exists (see FIFO).

FIFO:
- Push on lu_valid_i && lu_ready_o, except when lu_addr_i=0. Such a handshake completes but the entry is discarded.
- lu_ready_o = count < FIFO_DEPTH, combinational from registered count.
- Push and pop in the same cycle when full is not allowed, because ready is already low.
- Push and pop in the same cycle otherwise leaves the count unchanged.
- Pointers wrap modulo FIFO_DEPTH.

Scoreboard (REG_COUNT-bit pending vector):
- issue_i sets bit issue_addr_i. Bit 0 is never set.
- A FIFO pop clears the bit of the popped address.
- Set and clear of the same address in the same cycle: set wins.
- busyN_o = pending[chk_addrN_i], combinational. The bits are registered, so an issue in cycle N shows busy from cycle N+1.
- Protocol assertions:
  - Issuing to an already-pending register is illegal.
  - pipe_we_i to a pending register is illegal.

Starvation FSM (states RUN, STALL):
- RUN: the counter increments when the FIFO is non-empty and the pipeline wins. It clears when the FIFO pops or the FIFO is empty.
- When the counter reaches STARVE_LIMIT, the next state is STALL and the counter clears.
- STALL: stall_o=1 for exactly one cycle, the head pops, and the next state is RUN.
- The pipeline asserting pipe_we_i while stall_o=1 is an assertion failure. The block ignores that write.

## Timing
- Reset (rst_n low, asynchronous):
  - FIFO empty; lu_ready_o=1.
  - Pending vector cleared; busy1_o=busy2_o=0.
  - FSM in RUN, counter 0; stall_o=0.
  - we_o forced to 0 while rst_n=0; wr_addr_o and wr_data_o are don't-care.
- Pipeline write: same-cycle pass-through; 0-cycle added latency.
- Long-latency result accepted in cycle N: earliest on the port in cycle N+1, written into the register file at the end of N+1.
- Busy bit of a long-latency destination: high from the cycle after issue through the cycle its write is on the port. It is low from the next cycle.
- stall_o is registered. It asserts on the cycle after the counter reaches STARVE_LIMIT.
- Reset asserted mid-operation flushes buffered results; the issuer must re-issue.

## Structure
- `defines` package:
  - Add typedef wb_entry_t, a packed struct {addr[ADDR_WIDTH], data[DATA_WIDTH]}.
  - Add enum wb_state_e {RUN, STALL}.
  - Reuse ADDR_WIDTH, DATA_WIDTH and REG_COUNT.
- Sub-module wb_fifo:
  - Synchronous FIFO of wb_entry_t, parameterised by depth.
  - Ports: push, pop, full, empty, head, count.
- The top level holds the arbitration mux, the scoreboard and the FSM.

## Test plan
- Reset:
  - Assert rst_n=0 mid-burst with 3 entries queued.
  - Required: lu_ready_o=1, busy=0, we_o=0 immediately; no writes after release.
- Idle drain:
  - issue x5, then lu result x5=0xDEADBEEF, pipe idle.
  - Required: busy1_o(x5)=1 from the issue+1 cycle; we_o=1, addr 5, data 0xDEADBEEF one cycle after acceptance; busy clears the cycle after.
- Priority:
  - Pipe writes x3=0x11 in the same cycle the FIFO holds x7=0x22.
  - Required: port carries x3 that cycle; x7 written next idle cycle.
- Full:
  - Pipe writes every cycle with STARVE_LIMIT=8; push 4 results.
  - Required: lu_ready_o=0 after the 4th; a 5th valid is held until a pop.
- Starvation:
  - STARVE_LIMIT=4; pipe writes continuously; FIFO holds 1 entry.
  - Required: stall_o=1 for one cycle after 4 lost cycles; the head is written in that cycle.
- x0:
  - lu result to x0 with lu_valid_i=1.
  - Required: handshake completes; count unchanged; we_o never asserted for address 0.
